// File: rtl/point_controller.sv
// Purpose : rally/score controller downstream of the ball stage. It detects misses on x_min, awards points,
//           times the serve delay and drives the ball stage reset/start.
// Latency : a miss sampled at edge k updates the score at k; ball_reset rises after k+1. game_over/winner follow
//           the point by one edge.
// Backpr. : none. The 'play' level freezes the serve countdown and miss scoring; ball_start follows it one edge later.
// Ports   : clk, reset (async active-low), play, new_game (pulse), x_min[9:0] in;
//           ball_reset, ball_start, score1[3:0], score2[3:0], game_over, winner[1:0] out.
module point_controller #(
    parameter int BALL_LEN     = 15,
    parameter int BALL_SPEED   = 2,
    parameter int SCREEN_WIDTH = 640,
    parameter int LEFT_LIMIT   = 0,
    parameter int SERVE_DELAY  = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic       new_game,
    input  logic [9:0] x_min,
    output logic       ball_reset,
    output logic       ball_start,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_DELAY - 1);
    localparam logic [10:0] WRAP_TH  = 11'(1024 - BALL_SPEED);
    localparam logic [10:0] LEFT_TH  = 11'(LEFT_LIMIT);
    localparam logic [10:0] RIGHT_TH = 11'(SCREEN_WIDTH);
    localparam logic [10:0] BALL_W   = 11'(BALL_LEN);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE_WAIT,
        S_RALLY,
        S_POINT,
        S_GAME_OVER
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_score1;
    logic [3:0]       r_score2;
    logic             r_game_over;
    logic [1:0]       r_winner;
    logic             r_ball_reset;
    logic             r_ball_start;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_score1_nxt;
    logic [3:0]       w_score2_nxt;
    logic             w_game_over_nxt;
    logic [1:0]       w_winner_nxt;
    logic             w_ball_reset_nxt;
    logic             w_ball_start_nxt;

    logic [10:0] w_x;
    logic        w_wrap;
    logic        w_left_miss;
    logic        w_right_miss;

    // A ball leaving past the left edge underflows x_min to just below 1024; the guard band of one
    // maximum step catches that, and also keeps the wrapped value from looking like a right miss.
    assign w_x          = {1'b0, x_min};
    assign w_wrap       = (w_x >= WRAP_TH);
    assign w_left_miss  = (w_x <= LEFT_TH) || w_wrap;
    assign w_right_miss = ((w_x + BALL_W) >= RIGHT_TH) && !w_wrap;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_score1_nxt     = r_score1;
        w_score2_nxt     = r_score2;
        w_game_over_nxt  = r_game_over;
        w_winner_nxt     = r_winner;
        // Ball controls follow the current state, so they lag the state register by one edge.
        w_ball_reset_nxt = 1'b1;
        w_ball_start_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (play) begin
                    w_state_nxt = S_SERVE_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_SERVE_WAIT: begin
                if (play) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_RALLY;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            S_RALLY: begin
                w_ball_reset_nxt = 1'b0;
                w_ball_start_nxt = play;
                if (play) begin
                    // Left miss is checked first so it wins if both fire.
                    if (w_left_miss) begin
                        if (r_score2 < WIN) begin
                            w_score2_nxt = r_score2 + 4'd1;
                        end
                        w_state_nxt = S_POINT;
                    end else if (w_right_miss) begin
                        if (r_score1 < WIN) begin
                            w_score1_nxt = r_score1 + 4'd1;
                        end
                        w_state_nxt = S_POINT;
                    end
                end
            end
            S_POINT: begin
                if ((r_score1 == WIN) || (r_score2 == WIN)) begin
                    w_state_nxt     = S_GAME_OVER;
                    w_game_over_nxt = 1'b1;
                    w_winner_nxt    = (r_score1 == WIN) ? 2'b01 : 2'b10;
                end else begin
                    w_state_nxt = S_SERVE_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_GAME_OVER: begin
                w_game_over_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // new_game overrides anything decided above, including a point on the same edge.
        if (new_game) begin
            w_state_nxt     = S_IDLE;
            w_score1_nxt    = 4'd0;
            w_score2_nxt    = 4'd0;
            w_game_over_nxt = 1'b0;
            w_winner_nxt    = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_score1     <= 4'd0;
            r_score2     <= 4'd0;
            r_game_over  <= 1'b0;
            r_winner     <= 2'b00;
            r_ball_reset <= 1'b1;
            r_ball_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_score1     <= w_score1_nxt;
            r_score2     <= w_score2_nxt;
            r_game_over  <= w_game_over_nxt;
            r_winner     <= w_winner_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_ball_start <= w_ball_start_nxt;
        end
    end

    assign ball_reset = r_ball_reset;
    assign ball_start = r_ball_start;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule

// File: tb/tb_point_controller.sv
// Purpose : scoreboard bench for point_controller with SERVE_DELAY=4 and WIN_SCORE=7.
// Latency : each tick's expected outputs are queued at the falling edge and compared just after the next rising edge.
// Backpr. : n/a.
module tb_point_controller;

    logic       clk;
    logic       reset;
    logic       play;
    logic       new_game;
    logic [9:0] x_min;
    logic       ball_reset;
    logic       ball_start;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic [1:0] winner;

    point_controller #(
        .BALL_LEN    (15),
        .BALL_SPEED  (2),
        .SCREEN_WIDTH(640),
        .LEFT_LIMIT  (0),
        .SERVE_DELAY (4),
        .WIN_SCORE   (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .new_game  (new_game),
        .x_min     (x_min),
        .ball_reset(ball_reset),
        .ball_start(ball_start),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       br;
        logic       bs;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       go;
        logic [1:0] win;
    } obs_t;

    localparam obs_t ALL    = '1;
    localparam obs_t SC_MSK = {1'b0, 1'b0, 4'hf, 4'hf, 1'b1, 2'b11};

    obs_t  act;
    obs_t  exp_q[$];
    obs_t  msk_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    assign act = {ball_reset, ball_start, score1, score2, game_over, winner};

    function automatic obs_t mk(logic br, logic bs, int s1, int s2, logic go, logic [1:0] win);
        return {br, bs, 4'(s1), 4'(s2), go, win};
    endfunction

    task automatic check(string nm, obs_t e, obs_t m);
        vectors++;
        if ((act & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL %s @%0t: got br=%b bs=%b s1=%0d s2=%0d go=%b win=%b, expected br=%b bs=%b s1=%0d s2=%0d go=%b win=%b (mask %h)",
                     nm, $time, act.br, act.bs, act.s1, act.s2, act.go, act.win,
                     e.br, e.bs, e.s1, e.s2, e.go, e.win, m);
        end
    endtask

    // Monitor: the outputs settle after every rising edge; compare them against the oldest queued expectation.
    initial begin
        obs_t  e;
        obs_t  m;
        string nm;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                m  = msk_q.pop_front();
                nm = name_q.pop_front();
                check(nm, e, m);
            end
        end
    end

    // Drive one tick of inputs and queue what the outputs must be after the following rising edge.
    task automatic tick(logic p, logic ng, logic [9:0] x, obs_t e, obs_t m, string nm);
        @(negedge clk);
        play     = p;
        new_game = ng;
        x_min    = x;
        exp_q.push_back(e);
        msk_q.push_back(m);
        name_q.push_back(nm);
    endtask

    // Serve sequence from IDLE or POINT: five ticks holding the ball, then it moves.
    task automatic reserve(int s1, int s2);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, s1, s2, 1'b0, 2'b00), ALL, "serve_hold");
        end
        tick(1'b1, 1'b0, 10'd156, mk(1'b0, 1'b1, s1, s2, 1'b0, 2'b00), ALL, "serve_go");
    endtask

    task automatic miss(logic [9:0] x, int s1, int s2, string nm);
        tick(1'b1, 1'b0, x, mk(1'b0, 1'b1, s1, s2, 1'b0, 2'b00), ALL, nm);
    endtask

    initial begin
        int n;
        play     = 1'b0;
        new_game = 1'b0;
        x_min    = 10'd156;
        reset    = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("reset_state", mk(1'b1, 1'b0, 0, 0, 1'b0, 2'b00), ALL);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // First serve from IDLE, then right misses at and around the right boundary.
        reserve(0, 0);
        miss(10'd626, 1, 0, "right_miss_626");
        reserve(1, 0);
        tick(1'b1, 1'b0, 10'd624, mk(1'b0, 1'b1, 1, 0, 1'b0, 2'b00), ALL, "no_miss_624");
        miss(10'd625, 2, 0, "right_miss_625");
        reserve(2, 0);

        // Left misses: wrapped underflow, exact limit, and the guard-band edge (left wins over right).
        miss(10'd1023, 2, 1, "wrap_miss_1023");
        reserve(2, 1);
        miss(10'd0, 2, 2, "left_miss_0");
        reserve(2, 2);
        tick(1'b1, 1'b0, 10'd1, mk(1'b0, 1'b1, 2, 2, 1'b0, 2'b00), ALL, "no_miss_1");
        miss(10'd1022, 2, 3, "wrap_miss_1022");

        // Pause during serve wait with the counter at 2.
        tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "pt_point");
        tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "pt_cnt2");
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "pause_hold");
        end
        tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "resume_1");
        tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "resume_2");
        tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "resume_3");
        tick(1'b1, 1'b0, 10'd156, mk(1'b0, 1'b1, 2, 3, 1'b0, 2'b00), ALL, "serve_after_pause");

        // Pause in rally: ball stops, misses ignored.
        tick(1'b0, 1'b0, 10'd626, mk(1'b0, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "rally_paused_r");
        tick(1'b0, 1'b0, 10'd0,   mk(1'b0, 1'b0, 2, 3, 1'b0, 2'b00), ALL, "rally_paused_l");
        tick(1'b1, 1'b0, 10'd156, mk(1'b0, 1'b1, 2, 3, 1'b0, 2'b00), ALL, "rally_resume");

        // Paddle 2 runs to the winning score.
        miss(10'd0, 2, 4, "p2_point4");
        reserve(2, 4);
        miss(10'd0, 2, 5, "p2_point5");
        reserve(2, 5);
        miss(10'd0, 2, 6, "p2_point6");
        reserve(2, 6);
        miss(10'd0, 2, 7, "p2_point7");
        tick(1'b1, 1'b0, 10'd156, mk(1'b1, 1'b0, 2, 7, 1'b1, 2'b10), ALL, "game_over");
        tick(1'b1, 1'b0, 10'd0,   mk(1'b1, 1'b0, 2, 7, 1'b1, 2'b10), ALL, "go_hold_left");
        tick(1'b1, 1'b0, 10'd626, mk(1'b1, 1'b0, 2, 7, 1'b1, 2'b10), ALL, "go_hold_right");
        tick(1'b1, 1'b0, 10'd1023, mk(1'b1, 1'b0, 2, 7, 1'b1, 2'b10), ALL, "go_hold_wrap");

        // new_game clears and returns to IDLE.
        tick(1'b1, 1'b1, 10'd156, mk(1'b1, 1'b0, 0, 0, 1'b0, 2'b00), ALL, "new_game_clear");
        tick(1'b0, 1'b0, 10'd156, mk(1'b1, 1'b0, 0, 0, 1'b0, 2'b00), ALL, "idle_hold");
        reserve(0, 0);

        // new_game beats a miss on the same edge.
        tick(1'b1, 1'b1, 10'd626, mk(1'b0, 1'b0, 0, 0, 1'b0, 2'b00), SC_MSK, "ng_priority");
        tick(1'b0, 1'b0, 10'd156, mk(1'b1, 1'b0, 0, 0, 1'b0, 2'b00), ALL, "ng_idle");
        reserve(0, 0);
        miss(10'd626, 1, 0, "pre_reset_miss");
        reserve(1, 0);

        // Asynchronous reset mid-rally, away from any clock edge.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", mk(1'b1, 1'b0, 0, 0, 1'b0, 2'b00), ALL);
        @(posedge clk);
        #1;
        check("reset_held", mk(1'b1, 1'b0, 0, 0, 1'b0, 2'b00), ALL);
        @(negedge clk);
        play  = 1'b0;
        reset = 1'b1;
        reserve(0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #3;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
